btn_evt_dec: RTL

//  Consumer end of the debounced-button path. Takes the clean level from the button

---
 rtl/btn_evt_dec_pkg.sv | 15 +
 rtl/btn_evt_dec_edge.sv | 29 ++
 rtl/btn_evt_dec.sv | 132 +++++++++++++
 3 files changed

// File: rtl/btn_evt_dec_pkg.sv
// Shared definitions for debounced-button consumers.
// Holds the classifier state encoding so other button blocks can reuse it.
package btn_evt_dec_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } btn_state_e;

endpackage

// File: rtl/btn_evt_dec_edge.sv
// Registers the debounced button level and derives one-clk rise/fall strobes
// from the live input against the registered copy.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_q,
  output logic rise,
  output logic fall
);

  logic btn_d;

  always_comb begin
    btn_d = btn_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;

endmodule

// File: rtl/btn_evt_dec.sv
// Button event classifier: turns the debounced level plus the ce tick into
// one-clk CLICK / DBL / LONG / REP pulses.
module btn_evt_dec
  import btn_evt_dec_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LONG_TICKS = 50,
  parameter int DBL_TICKS  = 20,
  parameter int REP_TICKS  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic BTN_IN,
  output logic CLICK,
  output logic DBL,
  output logic LONG,
  output logic REP,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_TICKS - 1);

  logic       btn_q;
  logic       rise;
  logic       fall;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             click_q, click_d;
  logic             dbl_q, dbl_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             tmr_clr;

  btn_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (BTN_IN),
    .btn_q  (btn_q),
    .rise   (rise),
    .fall   (fall)
  );

  logic tmo_long, tmo_dbl, tmo_rep;
  assign tmo_long = ce & (timer_q == LONG_LAST);
  assign tmo_dbl  = ce & (timer_q == DBL_LAST);
  assign tmo_rep  = ce & (timer_q == REP_LAST);

  always_comb begin
    state_d = state_q;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    tmr_clr = 1'b0;
    // Edges are tested before timeouts so an edge wins a same-clk collision.
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (tmo_long) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (tmo_dbl) begin
          state_d = IDLE;
          click_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d = IDLE;
          dbl_d   = 1'b1;
        end else if (tmo_long) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
        end else if (tmo_rep) begin
          rep_d   = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    timer_d = timer_q;
    if ((state_d != state_q) || tmr_clr) begin
      timer_d = '0;
    end else if (ce && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      click_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      click_q <= click_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign CLICK = click_q;
  assign DBL   = dbl_q;
  assign LONG  = long_q;
  assign REP   = rep_q;
  assign BUSY  = (state_q != IDLE);

endmodule
